// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the controller state encoding and the helpers that split a byte
// address into offset / index / tag fields from the cache geometry.
package icache_pkg;

  // Controller states: a request is looked up, and on a miss the line is
  // requested, awaited and then written into the chosen way.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL
  } cacheState_e;

  // Byte-offset bits inside one line (line width given in bits).
  function automatic int offsetWidth(input int lineW);
    return $clog2(lineW / 8);
  endfunction

  // Set-index bits.
  function automatic int indexWidth(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: everything above offset and index.
  function automatic int tagWidth(input int addrW, input int sets, input int lineW);
    return addrW - offsetWidth(lineW) - indexWidth(sets);
  endfunction

  // Bits needed to name a way; a direct-mapped cache still gets one bit so
  // that the round-robin pointers have a legal width.
  function automatic int wayIdxWidth(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and line data.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset (clears valids)
//   flush_i      - clear every valid bit of this way in one cycle
//   rdIdx_i      - set being looked up; rd*_o are combinational reads
//   rdValid_o    - valid bit of the addressed set
//   rdTag_o      - stored tag of the addressed set
//   rdData_o     - stored line of the addressed set
//   wrEn_i       - write tag/data and set valid at wrIdx_i
//   wrIdx_i, wrTag_i, wrData_i - write address and contents
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  rdIdx_i,
  output logic              rdValid_o,
  output logic [TAG_W-1:0]  rdTag_o,
  output logic [LINE_W-1:0] rdData_o,
  input  logic              wrEn_i,
  input  logic [IDX_W-1:0]  wrIdx_i,
  input  logic [TAG_W-1:0]  wrTag_i,
  input  logic [LINE_W-1:0] wrData_i
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Valid bits are the only state that must be reset; flush wins over a
  // write so that a flushed cycle never leaves a freshly valid line behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIdx_i] <= 1'b1;
    end
  end

  // Tag and data storage need no reset because the valid bit guards them.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      tag_q[wrIdx_i]  <= wrTag_i;
      data_q[wrIdx_i] <= wrData_i;
    end
  end

  assign rdValid_o = valid_q[rdIdx_i];
  assign rdTag_o   = tag_q[rdIdx_i];
  assign rdData_o  = data_q[rdIdx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative, blocking instruction cache with one outstanding fetch.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req_valid/req_addr       - fetch request (offset bits ignored)
//   req_ready                - request accepted this cycle (IDLE, no flush)
//   kill                     - cancel the outstanding fetch
//   flush                    - invalidate every line
//   rsp_valid/rsp_data       - one-cycle response carrying the fetched line
//   miss_valid/miss_ready    - line-fill request handshake to memory
//   miss_addr                - line-aligned miss address
//   fill_valid/fill_data     - one-cycle line fill from memory
module icache_assoc
  import icache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              kill,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [LINE_W-1:0] rsp_data,
  output logic              miss_valid,
  input  logic              miss_ready,
  output logic [ADDR_W-1:0] miss_addr,
  input  logic              fill_valid,
  input  logic [LINE_W-1:0] fill_data
);

  localparam int OFF_W  = offsetWidth(LINE_W);
  localparam int IDX_W  = indexWidth(SETS);
  localparam int TAG_W  = tagWidth(ADDR_W, SETS, LINE_W);
  localparam int LINE_A = ADDR_W - OFF_W;
  localparam int WAY_W  = wayIdxWidth(WAYS);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  cacheState_e state_q, state_d;

  logic [LINE_A-1:0] reqLine_q, reqLine_d;
  logic              drop_q, drop_d;
  logic              noWrite_q, noWrite_d;
  logic [LINE_W-1:0] fillData_q, fillData_d;
  logic              rspValid_q, rspValid_d;
  logic [LINE_W-1:0] rspData_q, rspData_d;

  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;
  logic [OFF_W-1:0]  unusedOffset;

  logic [WAYS-1:0]   wayValid;
  logic [WAYS-1:0]   wayHit;
  logic [WAYS-1:0]   wayWrEn;
  logic [TAG_W-1:0]  wayTag  [WAYS];
  logic [LINE_W-1:0] wayData [WAYS];
  logic [LINE_W-1:0] hitData;
  logic              anyHit;

  logic [WAY_W-1:0]  rrPtr_q [SETS];
  logic [WAY_W-1:0]  rrNext;
  logic [WAY_W-1:0]  victim;
  logic              foundFree;
  logic              doWrite;

  // Only the line part of the address is kept; the offset is deliberately
  // dropped because a response always carries the whole line.
  assign unusedOffset = req_addr[OFF_W-1:0];
  assign reqIdx       = reqLine_q[IDX_W-1:0];
  assign reqTag       = reqLine_q[LINE_A-1:IDX_W];

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    icache_way #(
      .SETS   (SETS),
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
    ) uWay (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush),
      .rdIdx_i   (reqIdx),
      .rdValid_o (wayValid[w]),
      .rdTag_o   (wayTag[w]),
      .rdData_o  (wayData[w]),
      .wrEn_i    (wayWrEn[w]),
      .wrIdx_i   (reqIdx),
      .wrTag_i   (reqTag),
      .wrData_i  (fillData_q)
    );
  end

  // Tag compare across all ways. At most one way can match because a line
  // is only ever filled after a miss on the same set and tag.
  always_comb begin
    wayHit  = '0;
    hitData = '0;
    for (int w = 0; w < WAYS; w++) begin
      wayHit[w] = wayValid[w] && (wayTag[w] == reqTag);
      if (wayHit[w]) begin
        hitData = hitData | wayData[w];
      end
    end
  end

  assign anyHit = |wayHit;

  // Victim choice: the lowest invalid way if any exists, otherwise the
  // set's round-robin pointer.
  always_comb begin
    victim    = rrPtr_q[reqIdx];
    foundFree = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!foundFree && !wayValid[w]) begin
        victim    = WAY_W'(w);
        foundFree = 1'b1;
      end
    end
  end

  // Decode the single refill write onto the chosen way.
  always_comb begin
    wayWrEn = '0;
    for (int w = 0; w < WAYS; w++) begin
      wayWrEn[w] = doWrite && (victim == WAY_W'(w));
    end
  end

  assign rrNext = (rrPtr_q[reqIdx] == LAST_WAY) ? '0 : rrPtr_q[reqIdx] + 1'b1;

  // Round-robin pointers move on every refill write into the set, whether
  // or not the victim came from the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rrPtr_q[s] <= '0;
      end
    end else if (doWrite) begin
      rrPtr_q[reqIdx] <= rrNext;
    end
  end

  // State and datapath registers. Reset abandons any miss in flight, so a
  // fill arriving afterwards finds the controller in IDLE and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      reqLine_q  <= '0;
      drop_q     <= 1'b0;
      noWrite_q  <= 1'b0;
      fillData_q <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
    end else begin
      state_q    <= state_d;
      reqLine_q  <= reqLine_d;
      drop_q     <= drop_d;
      noWrite_q  <= noWrite_d;
      fillData_q <= fillData_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end

  // Next-state logic. drop_q remembers a kill that arrived while memory
  // was already fetching the line: the fill is still cached, just not
  // returned. noWrite_q remembers a flush in the same window: the line is
  // returned but must not land in a cache that was just invalidated.
  always_comb begin
    state_d    = state_q;
    reqLine_d  = reqLine_q;
    drop_d     = drop_q;
    noWrite_d  = noWrite_q;
    fillData_d = fillData_q;
    rspValid_d = 1'b0;
    rspData_d  = rspData_q;
    doWrite    = 1'b0;

    unique case (state_q)
      IDLE: begin
        drop_d    = 1'b0;
        noWrite_d = 1'b0;
        if (req_valid && !flush) begin
          reqLine_d = req_addr[ADDR_W-1:OFF_W];
          state_d   = LOOKUP;
        end
      end

      LOOKUP: begin
        if (kill) begin
          state_d = IDLE;
        end else if (anyHit) begin
          rspValid_d = 1'b1;
          rspData_d  = hitData;
          state_d    = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end

      MISS_REQ: begin
        if (kill) begin
          state_d = IDLE;
        end else if (miss_ready) begin
          state_d = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        if (kill) begin
          drop_d = 1'b1;
        end
        if (flush) begin
          noWrite_d = 1'b1;
        end
        if (fill_valid) begin
          fillData_d = fill_data;
          state_d    = REFILL;
        end
      end

      REFILL: begin
        doWrite = !noWrite_q && !flush;
        if (!drop_q && !kill) begin
          rspValid_d = 1'b1;
          rspData_d  = fillData_q;
        end
        drop_d    = 1'b0;
        noWrite_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A kill withdraws the memory request in the same cycle; the address is
  // driven only while a request is pending so it reads as zero otherwise.
  assign req_ready  = (state_q == IDLE) && !flush && !rst;
  assign miss_valid = (state_q == MISS_REQ) && !kill;
  assign miss_addr  = (state_q == MISS_REQ) ? {reqLine_q, {OFF_W{1'b0}}} : '0;
  assign rsp_valid  = rspValid_q;
  assign rsp_data   = rspData_q;

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter SETS, default 16, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter WAYS, default 2, associativity (power of 2, 1..8).
REQ-003 SHALL have parameter LINE_W, default 256, line width in bits (power of 2 bytes, >=64).
REQ-004 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  fetch request.
REQ-008 SHALL have port req_addr  input  ADDR_W  fetch byte address; offset bits ignored.
REQ-009 SHALL have port req_ready  output  1  request accepted this cycle.
REQ-010 SHALL have port kill  input  1  cancel outstanding fetch (exception/redirect).
REQ-011 SHALL have port flush  input  1  invalidate all lines.
REQ-012 SHALL have port rsp_valid  output  1  rsp_data valid, one-cycle pulse.
REQ-013 SHALL have port rsp_data  output  LINE_W  fetched line.
REQ-014 SHALL have port miss_valid  output  1  line-fill request to memory.
REQ-015 SHALL have port miss_ready  input  1  memory accepts miss request.
REQ-016 SHALL have port miss_addr  output  ADDR_W  line-aligned miss address (offset bits zero).
REQ-017 SHALL have port fill_valid  input  1  fill data present, one-cycle pulse.
REQ-018 SHALL have port fill_data  input  LINE_W  fill line.

Function
REQ-019 Address split SHALL be offset=log2(LINE_W/8), index=log2(SETS), tag=remaining upper bits.
REQ-020 FSM states SHALL be IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL.
REQ-021 req_ready SHALL be 1 only in IDLE with flush=0; accepted request registered, IDLE->LOOKUP.
REQ-022 LOOKUP hit (valid and tag equal in any way): rsp_valid=1 next cycle with that way's line, ->IDLE; hit latency 2 cycles from acceptance.
REQ-023 LOOKUP miss: ->MISS_REQ; miss_valid held 1 with stable miss_addr until miss_ready=1, then ->MISS_WAIT.
REQ-024 MISS_WAIT on fill_valid: ->REFILL; REFILL writes tag, data, valid=1 into victim way, rsp_valid=1 next cycle with fill_data, ->IDLE.
REQ-025 Victim SHALL be lowest-numbered invalid way; if all valid, per-set round-robin pointer, pointer advanced only on REFILL write.
REQ-026 More than one way SHALL never hold the same tag within a set.
REQ-027 kill in LOOKUP or MISS_REQ SHALL return FSM to IDLE with no response; miss_valid dropped same cycle.
REQ-028 kill in MISS_WAIT SHALL set drop flag; FSM stays until fill_valid, fill then written to cache, no rsp_valid, ->IDLE.
REQ-029 flush SHALL clear all valid bits in one cycle; in MISS_WAIT/REFILL the pending fill SHALL NOT be written, rsp still returned unless killed.
REQ-030 kill and flush same cycle: both effects apply.
REQ-031 fill_valid outside MISS_WAIT SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE, all valid bits 0, round-robin pointers 0, drop flag 0.
REQ-033 Reset outputs: req_ready=0 during rst, rsp_valid=0, miss_valid=0, miss_addr=0, rsp_data=0.
REQ-034 rst mid-miss SHALL abandon the miss; a later stray fill_valid is ignored.

Structure
REQ-035 Shared package icache_pkg SHALL hold FSM state enum and address-split width functions.
REQ-036 Tag/valid/data arrays SHALL be one sub-module icache_way, instantiated WAYS times.

Verification
REQ-037 Cold miss addr 0x0000_1040: miss_addr=0x0000_1040, fill 0xA5.. -> rsp_data=0xA5.., repeat -> hit in 2 cycles, no miss_valid.
REQ-038 WAYS=2: fill 0x000,0x200,0x400 same set -> 0x000 evicted; 0x200 and 0x400 hit, 0x000 misses.
REQ-039 miss_ready held 0 for 5 cycles -> miss_valid and miss_addr stable all 5 cycles.
REQ-040 kill in MISS_WAIT then fill -> no rsp_valid; same address next -> hit.
REQ-041 flush during MISS_WAIT -> rsp returned; same address next -> miss.
REQ-042 rst asserted in MISS_WAIT, fill_valid next cycle -> no rsp_valid, all lookups miss.
